// File: rtl/md_sched_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
// Imported by md_alu and md_sched.
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath producing the 64-bit {hi, lo} result
// for mult/multu/div/divu, including the divide-by-zero and overflow cases.
module md_alu
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        div_zero;
  logic        div_ovf;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign q_s = $signed(a) / $signed(b);
  assign r_s = $signed(a) % $signed(b);
  assign q_u = a / b;
  assign r_u = a % b;

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    res = 64'd0;
    case (md_op_t'(op))
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (div_zero)     res = {a, 32'hFFFF_FFFF};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {r_s, q_s};
      end
      MD_DIVU: begin
        if (div_zero) res = {a, 32'hFFFF_FFFF};
        else          res = {r_u, q_u};
      end
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, with the ID-stage stall
// that keeps later HI/LO users out of EX while a result is in flight.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [2:0]  MDOp_EX,
  input  logic [31:0] A_EX,
  input  logic [31:0] B_EX,
  input  logic        isMD_ID,
  output logic        Busy,
  output logic        Start,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        state_dbg
);

  md_op_t             op;
  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        stage_hi;
  logic [31:0]        stage_lo;
  logic [63:0]        alu_res;
  logic               is_muldiv;
  logic               is_div;

  assign op        = md_op_t'(MDOp_EX);
  assign is_muldiv = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);

  // Accept handshake: EX offers an op (is_muldiv, the valid), the unit is ready
  // when ~Busy, and a CP0 Req withdraws the offer; Start marks the transfer.
  assign Start     = is_muldiv & ~Req & ~Busy;
  assign Stall_MD  = isMD_ID & (Busy | Start);
  assign state_dbg = state;

  md_alu u_alu (
    .op  (MDOp_EX),
    .a   (A_EX),
    .b   (B_EX),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      Busy     <= 1'b0;
      cnt      <= '0;
      stage_hi <= 32'd0;
      stage_lo <= 32'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            stage_hi <= alu_res[63:32];
            stage_lo <= alu_res[31:0];
            cnt      <= is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            Busy     <= 1'b1;
            state    <= ST_RUN;
          end else if (!Req && op == MD_MTHI) begin
            HI <= A_EX;
          end else if (!Req && op == MD_MTLO) begin
            LO <= A_EX;
          end
        end
        ST_RUN: begin
          // Req is deliberately ignored here: the owning instruction has retired.
          if (cnt == CNT_W'(1)) begin
            HI    <= stage_hi;
            LO    <= stage_lo;
            Busy  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios followed by random
// traffic, all checked every cycle against a cycle-count reference model.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [2:0]  MDOp_EX;
  logic [31:0] A_EX;
  logic [31:0] B_EX;
  logic        isMD_ID;
  logic        Busy;
  logic        Start;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_sched dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .MDOp_EX   (MDOp_EX),
    .A_EX      (A_EX),
    .B_EX      (B_EX),
    .isMD_ID   (isMD_ID),
    .Busy      (Busy),
    .Start     (Start),
    .Stall_MD  (Stall_MD),
    .HI        (HI),
    .LO        (LO),
    .state_dbg (state_dbg)
  );

  // Reference model: architectural HI/LO, remaining busy cycles, pending results.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_left = 0;
  logic [63:0] exp_q[$];

  // Last sampled DUT outputs, for directed scenario checks.
  logic s_start, s_busy, s_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_md(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      1: res = sa * sb;
      2: res = ua * ub;
      3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa - q * sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua - uq * ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic cycle(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic req, input logic ismd, input logic rst);
    logic exp_start;
    logic exp_busy;
    logic [63:0] res;
    @(negedge clk);
    reset   = rst;
    Req     = req;
    MDOp_EX = op[2:0];
    A_EX    = a;
    B_EX    = b;
    isMD_ID = ismd;
    #1;
    exp_busy  = (m_left > 0);
    exp_start = !exp_busy && (op >= 1) && (op <= 4) && !req;
    check("busy", Busy, exp_busy);
    check("start", Start, exp_start);
    check("stall", Stall_MD, ismd && (exp_busy || exp_start));
    check("state", state_dbg, exp_busy);
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    s_start = Start;
    s_busy  = Busy;
    s_stall = Stall_MD;
    if (rst) begin
      exp_q.delete();
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && exp_q.size() > 0) begin
        res  = exp_q.pop_front();
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
    end else if (exp_start) begin
      exp_q.push_back(ref_md(op, a, b));
      m_left = (op >= 3) ? 10 : 5;
    end else if (!req && op == 5) begin
      m_hi = a;
    end else if (!req && op == 6) begin
      m_lo = a;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic ismd);
    for (int i = 0; i < n; i++) cycle(0, 32'd0, 32'd0, 1'b0, ismd, 1'b0);
  endtask

  // Issues one op, then idles until well past completion, returning busy length.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, output int nbusy);
    nbusy = 0;
    cycle(op, a, b, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      if (s_busy) nbusy++;
    end
    #2;
  endtask

  logic [31:0] hi_save, lo_save, ra, rb;
  int nb, nstall, rop;

  initial begin
    reset = 1'b1; Req = 1'b0; MDOp_EX = 3'd0; A_EX = 32'd0; B_EX = 32'd0; isMD_ID = 1'b0;
    cycle(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    #2;
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", Busy, 1'b0);

    run_op(1, 32'hFFFF_FFFE, 32'd3, nb);
    check("mult_busy_len", nb, 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    run_op(2, 32'hFFFF_FFFF, 32'd2, nb);
    check("multu_busy_len", nb, 5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    run_op(3, 32'hFFFF_FFF9, 32'd2, nb);
    check("div_busy_len", nb, 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    run_op(3, 32'd5, 32'd0, nb);
    check("div0_lo", LO, 32'hFFFF_FFFF);
    check("div0_hi", HI, 32'd5);

    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    // mult in EX with mflo waiting in ID: six stalled cycles, seventh free.
    nstall = 0;
    cycle(1, 32'd7, 32'd6, 1'b0, 1'b1, 1'b0);
    if (s_stall) nstall++;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      if (s_stall) nstall++;
    end
    check("stall_len", nstall, 6);
    cycle(0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("stall_7th", s_stall, 1'b0);
    check("stall_7th_lo", LO, 32'd42);

    hi_save = HI; lo_save = LO;
    cycle(3, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    check("req_div_start", s_start, 1'b0);
    cycle(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("req_div_busy", s_busy, 1'b0);
    idle(11, 1'b0);
    #2;
    check("req_div_hi", HI, hi_save);
    check("req_div_lo", LO, lo_save);

    cycle(5, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    #2;
    check("req_mthi", HI, hi_save);
    cycle(5, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle(6, 32'h5678, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    #2;
    check("mthi", HI, 32'h1234);
    check("mtlo", LO, 32'h5678);

    cycle(1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 32'd0, 32'd0, i[0], 1'b0, 1'b0);
    #2;
    check("req_midrun_lo", LO, 32'd12);
    check("req_midrun_busy", Busy, 1'b0);

    cycle(1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("rst_midrun_busy", s_busy, 1'b0);
    idle(8, 1'b0);
    #2;
    check("rst_midrun_hi", HI, 32'd0);
    check("rst_midrun_lo", LO, 32'd0);

    for (int i = 0; i < 600; i++) begin
      rop = $urandom_range(0, 7);
      ra  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      cycle(rop, ra, rb, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 99) == 0));
    end
    idle(12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from EX and runs them over a fixed number of cycles.
- Produces the ID-stage stall that holds any later HI/LO-touching instruction in ID while the unit is busy.
- Honours the CP0 exception/interrupt request so a cancelled instruction never commits to HI/LO.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu, counted after the start cycle.
- DIV_CYC, 10, busy cycles for div/divu, counted after the start cycle.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Req  in  1  CP0 exception/interrupt request; flushes the instruction currently in EX.
- MDOp_EX  in  3  operation of the instruction in EX: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is treated as none.
- A_EX  in  32  forwarded rs value.
- B_EX  in  32  forwarded rt value.
- isMD_ID  in  1  instruction in ID reads or writes HI/LO (any of the six ops above, or mfhi/mflo).
- Busy  out  1  unit is computing.
- Start  out  1  combinational: a mult/div is being accepted this cycle.
- Stall_MD  out  1  combinational: hold ID and insert a bubble into EX.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, cycle counter=0, state IDLE; result staging registers cleared.
- States: IDLE, RUN.
- Acceptance (IDLE):
  - Start = (MDOp_EX in 1..4) & ~Req & ~Busy.
  - On Start: latch the operation result into staging registers, load counter with MULT_CYC or DIV_CYC, set Busy=1, go to RUN.
- RUN:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1: HI/LO take the staged result at the clock edge, Busy falls, state returns to IDLE.
  - The next op may start in the cycle immediately after Busy falls.
- Arithmetic:
  - mult: signed 32x32 to 64. multu: unsigned. HI = upper 32 bits, LO = lower 32 bits.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = A_EX, with no exception.
  - Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - Written at the edge ending the EX cycle when ~Req & ~Busy.
  - Stall guarantees they never reach EX while Busy=1.
  - If MDOp_EX holds an mthi/mtlo while Busy=1 (illegal), it is ignored.
- Req handling:
  - Req=1 suppresses Start and any mthi/mtlo in that cycle.
  - An operation already in RUN is not cancelled: it completes and commits, because its instruction has already retired past EX.
- Stall: Stall_MD = isMD_ID & (Busy | Start).
  - The Start term covers back-to-back mult followed by mflo.
  - Stall_MD is never asserted when isMD_ID=0.
- Simultaneous events:
  - Reset has priority over everything, including during RUN; staged results are discarded and HI/LO clear.
  - Completion and a new Start never coincide, because Start requires Busy=0.
- HI/LO outputs change only at commit edges. mfhi/mflo reads after Busy falls see the new value with no forwarding needed.

Decomposition:
- Shared package/header holds:
  - MDOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - State encodings IDLE/RUN.
  - Default latencies.
- The decoder emitting MDOp and isMD is the existing control unit extended with these codes.
- One natural sub-module: md_alu, combinational.
  - Computes the 64-bit {hi,lo} for ops 1..4, including the divide-by-zero and overflow rules.
  - md_sched owns all state, the counter and the stall.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3:
  - Start=1 for one cycle, Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), Busy high for 10 cycles.
- div A=5, B=0 → LO=0xFFFFFFFF, HI=5.
- div A=0x80000000, B=-1 → LO=0x80000000, HI=0.
- mult in EX with isMD_ID=1 (mflo) the same cycle:
  - Stall_MD=1 on the Start cycle and all 5 busy cycles (6 cycles total).
  - Stall_MD=0 on the 7th cycle, when LO already holds the product.
- Req=1 alongside MDOp_EX=div → Start=0, Busy stays 0, HI/LO unchanged.
- Req=1 alongside mthi 0x1234 → HI unchanged.
- Req=1 raised mid-RUN → still commits on schedule.
- Reset asserted in the 3rd busy cycle of mult → next cycle Busy=0, HI=LO=0, and no late commit follows.
